// File: rtl/srq_collector_pkg.sv
// Shared definitions for the service-request collector.
//  - CPU op-bit indices decoded outside this block into the strobe inputs
//  - well-known channel indices
//  - par view selector and the lowest-set-bit encoder used for par
package srq_collector_pkg;

    // Op-bit indices of the CPU instruction word that generate the strobes.
    localparam int GET_SRQ      = 0;
    localparam int GET_SRQ_OVR  = 1;
    localparam int SET_SRQ_MASK = 2;
    localparam int SET_SRQ_MODE = 3;

    // Channel assignments.
    localparam int SRQ_HOST = 0;
    localparam int SRQ_GPS  = 1;

    localparam int NCHAN_MAX = 8;

    // Which snapshot par presents. VIEW_NONE keeps par at zero until the
    // first strobe after reset.
    typedef enum logic [1:0] {
        VIEW_NONE = 2'd0,
        VIEW_SRQ  = 2'd1,
        VIEW_OVR  = 2'd2
    } par_view_e;

    // Index of the lowest set bit, 4'hF when no bit is set.
    function automatic logic [3:0] lowest_set(input logic [NCHAN_MAX-1:0] v);
        lowest_set = 4'hF;
        for (int i = NCHAN_MAX - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 4'(i);
        end
    endfunction

endpackage

// File: rtl/srq_collector_chan.sv
// One request channel: edge detect, sticky pending, sticky overrun and the
// per-channel mask and mode bits.
// Ports:
//  clk, rst      clock, asynchronous active-high reset
//  src           request input (clk domain)
//  rd_stb        snapshot-and-clear strobe
//  rd_ovr_stb    overrun read-and-clear strobe
//  wr_mask/_mode write strobes, mask_wd/mode_wd the new bit values
//  pending, mask, ovr   current register values
//  irq_next      pending & mask as they will be after this edge
module srq_chan
    import srq_collector_pkg::*;
#(
    parameter logic MASK_RST = 1'b0,
    parameter logic EDGE_RST = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic rd_stb,
    input  logic rd_ovr_stb,
    input  logic wr_mask,
    input  logic wr_mode,
    input  logic mask_wd,
    input  logic mode_wd,
    output logic pending,
    output logic mask,
    output logic ovr,
    output logic irq_next
);

    logic src_d;
    logic mode;
    logic evt;
    logic ovr_set;
    logic pending_next;
    logic mask_next;
    logic mode_next;
    logic ovr_next;

    // NOTE: every always_comb output gets a value on every path (defaults
    // first) so no latch is inferred.
    always_comb begin
        evt          = mode ? (src & ~src_d) : src;
        // A read only clears the channel if it was enabled; an event in the
        // read cycle is re-latched so it is never lost.
        pending_next = rd_stb ? ((pending & ~mask) | evt) : (pending | evt);
        // An event that lands on a pending bit being read out is not an overrun.
        ovr_set      = evt & pending & ~(rd_stb & mask);
        ovr_next     = rd_ovr_stb ? ovr_set : (ovr | ovr_set);
        mask_next    = wr_mask ? mask_wd : mask;
        mode_next    = wr_mode ? mode_wd : mode;
        irq_next     = pending_next & mask_next;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_d   <= 1'b0;
            pending <= 1'b0;
            ovr     <= 1'b0;
            mask    <= MASK_RST;
            mode    <= EDGE_RST;
        end else begin
            // src_d tracks src regardless of mode, so switching level->edge
            // with src already high does not create an edge.
            src_d   <= src;
            pending <= pending_next;
            ovr     <= ovr_next;
            mask    <= mask_next;
            mode    <= mode_next;
        end
    end

endmodule

// File: rtl/srq_collector.sv
// Collects NCHAN service-request sources into sticky pending bits and drives
// one interrupt, plus a read-and-clear snapshot for the CPU.
// Ports:
//  clk        cpu_clk
//  rst        asynchronous active-high reset
//  src        request inputs, clk domain
//  rd_stb     snapshot pending & mask, clear the enabled pending bits
//  rd_ovr_stb snapshot and clear overrun flags
//  wr_mask    mask <= tos[NCHAN-1:0]
//  wr_mode    mode <= tos[NCHAN-1:0] (1 = rising edge, 0 = level)
//  tos        CPU write data
//  par        {any, 3'b0, idx, snap} or {8'h0, ovr_snap}, whichever was read last
//  ser        any enabled request at the last rd_stb
//  irq        high while any enabled request is pending
module srq_collector
    import srq_collector_pkg::*;
#(
    parameter int         NCHAN    = 4,
    parameter logic [7:0] MASK_RST = 8'h01,
    parameter logic [7:0] EDGE_RST = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCHAN-1:0] src,
    input  logic             rd_stb,
    input  logic             rd_ovr_stb,
    input  logic             wr_mask,
    input  logic             wr_mode,
    input  logic [15:0]      tos,
    output logic [15:0]      par,
    output logic             ser,
    output logic             irq
);

    logic [NCHAN-1:0] pending;
    logic [NCHAN-1:0] mask;
    logic [NCHAN-1:0] ovr;
    logic [NCHAN-1:0] irq_next;
    logic [NCHAN-1:0] snap;
    logic [NCHAN-1:0] ovr_snap;
    par_view_e        view;

    logic [7:0] snap8;
    logic [7:0] ovr_snap8;
    logic [3:0] idx;

    // Write-data bits above NCHAN are deliberately ignored.
    logic unused_tos;
    assign unused_tos = ^tos[15:NCHAN];

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        srq_chan #(
            .MASK_RST (MASK_RST[i]),
            .EDGE_RST (EDGE_RST[i])
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .src        (src[i]),
            .rd_stb     (rd_stb),
            .rd_ovr_stb (rd_ovr_stb),
            .wr_mask    (wr_mask),
            .wr_mode    (wr_mode),
            .mask_wd    (tos[i]),
            .mode_wd    (tos[i]),
            .pending    (pending[i]),
            .mask       (mask[i]),
            .ovr        (ovr[i]),
            .irq_next   (irq_next[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap     <= '0;
            ovr_snap <= '0;
            view     <= VIEW_NONE;
            ser      <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq <= |irq_next;
            if (rd_stb) begin
                snap <= pending & mask;
                ser  <= |(pending & mask);
            end
            if (rd_ovr_stb) begin
                ovr_snap <= ovr;
            end
            // Both strobes together: the request view wins.
            if (rd_stb) begin
                view <= VIEW_SRQ;
            end else if (rd_ovr_stb) begin
                view <= VIEW_OVR;
            end
        end
    end

    always_comb begin
        snap8                 = '0;
        snap8[NCHAN-1:0]      = snap;
        ovr_snap8             = '0;
        ovr_snap8[NCHAN-1:0]  = ovr_snap;
        idx                   = lowest_set(snap8);
        par                   = '0;
        case (view)
            VIEW_SRQ: par = {|snap8, 3'b000, idx, snap8};
            VIEW_OVR: par = {8'h00, ovr_snap8};
            default:  par = '0;
        endcase
    end

endmodule

// File: tb/tb_srq_collector.sv
module tb_srq_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src = '0;
    logic        rd_stb = 1'b0;
    logic        rd_ovr_stb = 1'b0;
    logic        wr_mask = 1'b0;
    logic        wr_mode = 1'b0;
    logic [15:0] tos = '0;
    logic [15:0] par;
    logic        ser;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Expected par values, pushed when a strobe is driven.
    logic [15:0] exp_q[$];

    srq_collector #(
        .NCHAN    (4),
        .MASK_RST (8'h01),
        .EDGE_RST (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src        (src),
        .rd_stb     (rd_stb),
        .rd_ovr_stb (rd_ovr_stb),
        .wr_mask    (wr_mask),
        .wr_mode    (wr_mode),
        .tos        (tos),
        .par        (par),
        .ser        (ser),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Scoreboard: each strobe edge pops one expected par value.
    always @(posedge clk) begin
        if ((rd_stb || rd_ovr_stb) && !rst) begin
            logic [15:0] e;
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow par=%h expected=<none>", par);
            end else begin
                e = exp_q.pop_front();
                if (par !== e) begin
                    errors++;
                    $display("FAIL scoreboard_par t=%0t par=%h expected=%h", $time, par, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic rd, input logic rdo, input logic [15:0] exp_par);
        exp_q.push_back(exp_par);
        rd_stb     = rd;
        rd_ovr_stb = rdo;
        tick();
        rd_stb     = 1'b0;
        rd_ovr_stb = 1'b0;
    endtask

    task automatic write_reg(input logic is_mode, input logic [15:0] d);
        tos     = d;
        wr_mask = ~is_mode;
        wr_mode = is_mode;
        tick();
        wr_mask = 1'b0;
        wr_mode = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++;
        if (ser !== 1'b0) begin errors++; $display("FAIL reset_ser got=%b exp=0", ser); end
        checks++;
        if (par !== 16'h0000) begin errors++; $display("FAIL reset_par got=%h exp=0000", par); end
        rst = 1'b0;
        tick();
        strobe(1'b1, 1'b0, 16'h0F00);
        checks++;
        if (ser !== 1'b0) begin errors++; $display("FAIL reset_ser_after_rd got=%b exp=0", ser); end
    endtask

    task automatic test_level_ch0();
        src = 4'b0001;
        tick();
        src = 4'b0000;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL level_irq got=%b exp=1", irq); end
        strobe(1'b1, 1'b0, 16'h8001);
        checks++;
        if (ser !== 1'b1) begin errors++; $display("FAIL level_ser got=%b exp=1", ser); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL level_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_edge_ch2();
        write_reg(1'b1, 16'h0004);
        write_reg(1'b0, 16'h0005);
        src = 4'b0100;
        for (int i = 0; i < 10; i++) tick();
        src = 4'b0000;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL edge_irq got=%b exp=1", irq); end
        strobe(1'b1, 1'b0, 16'h8204);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_clear got=%b exp=0", irq); end
        // A single event leaves no overrun behind.
        strobe(1'b0, 1'b1, 16'h0000);
    endtask

    task automatic test_simultaneous();
        src = 4'b0001;
        tick();
        // New ch0 event coincides with the read of the pending ch0 bit.
        strobe(1'b1, 1'b0, 16'h8001);
        src = 4'b0000;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL simul_irq got=%b exp=1", irq); end
        strobe(1'b0, 1'b1, 16'h0000);
        strobe(1'b1, 1'b0, 16'h8001);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL simul_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_masked_latch();
        write_reg(1'b0, 16'h0001);
        src = 4'b1000;
        tick();
        src = 4'b0000;
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq got=%b exp=0", irq); end
        strobe(1'b1, 1'b0, 16'h0F00);
        write_reg(1'b0, 16'hFFF8);   // upper bits ignored -> mask=4'b1000
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL unmask_irq got=%b exp=1", irq); end
        strobe(1'b1, 1'b0, 16'h8308);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL unmask_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_overrun_and_reset();
        write_reg(1'b0, 16'h0002);
        src = 4'b0010;
        tick();
        tick();
        src = 4'b0000;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL ovr_irq got=%b exp=1", irq); end
        strobe(1'b0, 1'b1, 16'h0002);
        // Burst on ch1, reset lands between edges.
        for (int i = 0; i < 3; i++) begin
            src = 4'(i[0] ? 4'b0000 : 4'b0010);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rst_mid_irq got=%b exp=0", irq); end
        checks++;
        if (ser !== 1'b0) begin errors++; $display("FAIL rst_mid_ser got=%b exp=0", ser); end
        checks++;
        if (par !== 16'h0000) begin errors++; $display("FAIL rst_mid_par got=%h exp=0000", par); end
        src = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL post_rst_irq got=%b exp=0", irq); end
    endtask

    task automatic test_back_to_back();
        // Reset restored mask=4'b0001, level mode.
        src = 4'b0001;
        tick();
        strobe(1'b1, 1'b0, 16'h8001);
        strobe(1'b1, 1'b0, 16'h8001);
        src = 4'b0000;
        strobe(1'b1, 1'b0, 16'h8001);
        strobe(1'b1, 1'b0, 16'h0F00);
        checks++;
        if (ser !== 1'b0) begin errors++; $display("FAIL b2b_ser got=%b exp=0", ser); end
    endtask

    initial begin
        test_reset();
        test_level_ch0();
        test_edge_ch2();
        test_simultaneous();
        test_masked_latch();
        test_overrun_and_reset();
        test_back_to_back();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
